// File: rtl/beat_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : beat_scheduler
//  Description : Musical time base. Divides i_clk by a programmable period
//                into sub-beat ticks, groups sub-beats into beats and beats
//                into bars, with a one-bar count-in, pause/resume and tempo
//                changes that only take effect on beat boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module beat_scheduler #(
    parameter int               DIV_W      = 20,
    parameter logic [DIV_W-1:0] DEF_PERIOD = DIV_W'(187500),
    parameter int               SUBS       = 4,
    parameter int               BEATS      = 4,
    parameter int               BAR_W      = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_pause,
    input  logic                       i_stop,
    input  logic                       i_period_wr,
    input  logic [DIV_W-1:0]           i_period,
    output logic [1:0]                 o_state,
    output logic                       o_sub_tick,
    output logic                       o_beat_tick,
    output logic [$clog2(SUBS)-1:0]    o_sub_idx,
    output logic [$clog2(BEATS)-1:0]   o_beat_idx,
    output logic [BAR_W-1:0]           o_bar_cnt,
    output logic                       o_count_in,
    output logic                       o_period_err
);

    localparam int               SUB_W      = $clog2(SUBS);
    localparam int               BEAT_W     = $clog2(BEATS);
    localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'(SUBS - 1);
    localparam logic [BEAT_W-1:0] BEAT_FIRST = BEAT_W'(BEATS - 1);
    localparam logic [DIV_W-1:0]  MIN_PERIOD = DIV_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNT_IN = 2'd1,
        ST_RUN      = 2'd2,
        ST_PAUSE    = 2'd3
    } state_t;

    state_t             state_q,      state_d;
    state_t             resume_q,     resume_d;
    logic [DIV_W-1:0]   div_q,        div_d;
    logic [SUB_W-1:0]   sub_idx_q,    sub_idx_d;
    logic [BEAT_W-1:0]  beat_idx_q,   beat_idx_d;
    logic [BAR_W-1:0]   bar_cnt_q,    bar_cnt_d;
    logic               sub_tick_q,   sub_tick_d;
    logic               beat_tick_q,  beat_tick_d;
    logic               count_in_q,   count_in_d;
    logic               period_err_q, period_err_d;
    logic [DIV_W-1:0]   active_q,     active_d;
    logic [DIV_W-1:0]   pending_q,    pending_d;
    logic               pend_vld_q,   pend_vld_d;

    // Time base only advances while counting; a stop on the same edge wins.
    logic running;
    logic div_wrap;
    logic sub_wrap;
    logic beat_wrap;

    assign running   = ((state_q == ST_COUNT_IN) || (state_q == ST_RUN)) && !i_stop;
    assign div_wrap  = running && (div_q == (active_q - 1'b1));
    assign sub_wrap  = div_wrap && (sub_idx_q == SUB_LAST);
    assign beat_wrap = sub_wrap && (beat_idx_q == '0);

    // Next-state, counter and period-register logic.
    always_comb begin
        state_d      = state_q;
        resume_d     = resume_q;
        div_d        = div_q;
        sub_idx_d    = sub_idx_q;
        beat_idx_d   = beat_idx_q;
        bar_cnt_d    = bar_cnt_q;
        sub_tick_d   = 1'b0;
        beat_tick_d  = 1'b0;
        period_err_d = 1'b0;
        active_d     = active_q;
        pending_d    = pending_q;
        pend_vld_d   = pend_vld_q;

        // A pending tempo is adopted on the edge that produces a beat tick;
        // the divider is already restarting at 0 on that edge.
        if (sub_wrap && pend_vld_q) begin
            active_d   = pending_q;
            pend_vld_d = 1'b0;
        end

        // Writes below the minimum are dropped. While stopped the new tempo
        // is used at once; otherwise it waits for the next beat boundary.
        // Coming after the load above, a write on a beat edge stays pending.
        if (i_period_wr) begin
            if (i_period < MIN_PERIOD) begin
                period_err_d = 1'b1;
            end else if (state_q == ST_IDLE) begin
                active_d   = i_period;
                pending_d  = i_period;
                pend_vld_d = 1'b0;
            end else begin
                pending_d  = i_period;
                pend_vld_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!i_stop && i_start) begin
                    state_d = ST_COUNT_IN;
                end
                div_d      = '0;
                sub_idx_d  = '0;
                beat_idx_d = BEAT_FIRST;
                bar_cnt_d  = '0;
            end

            ST_COUNT_IN, ST_RUN: begin
                if (i_stop) begin
                    state_d    = ST_IDLE;
                    div_d      = '0;
                    sub_idx_d  = '0;
                    beat_idx_d = BEAT_FIRST;
                    bar_cnt_d  = '0;
                end else begin
                    div_d = div_wrap ? '0 : (div_q + 1'b1);
                    if (div_wrap) begin
                        sub_tick_d = 1'b1;
                        sub_idx_d  = sub_idx_q + 1'b1;
                    end
                    if (sub_wrap) begin
                        beat_tick_d = 1'b1;
                        beat_idx_d  = beat_idx_q - 1'b1;
                    end
                    if (beat_wrap) begin
                        if (state_q == ST_RUN) begin
                            bar_cnt_d = bar_cnt_q + 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                    // The edge carrying the pause still completes its update;
                    // resume goes to wherever that update would have led.
                    if (i_pause) begin
                        resume_d = state_d;
                        state_d  = ST_PAUSE;
                    end
                end
            end

            ST_PAUSE: begin
                if (i_stop) begin
                    state_d    = ST_IDLE;
                    div_d      = '0;
                    sub_idx_d  = '0;
                    beat_idx_d = BEAT_FIRST;
                    bar_cnt_d  = '0;
                end else if (i_start && !i_pause) begin
                    state_d = resume_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        count_in_d = (state_d == ST_COUNT_IN);
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            resume_q     <= ST_COUNT_IN;
            div_q        <= '0;
            sub_idx_q    <= '0;
            beat_idx_q   <= BEAT_FIRST;
            bar_cnt_q    <= '0;
            sub_tick_q   <= 1'b0;
            beat_tick_q  <= 1'b0;
            count_in_q   <= 1'b0;
            period_err_q <= 1'b0;
            active_q     <= DEF_PERIOD;
            pending_q    <= DEF_PERIOD;
            pend_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resume_q     <= resume_d;
            div_q        <= div_d;
            sub_idx_q    <= sub_idx_d;
            beat_idx_q   <= beat_idx_d;
            bar_cnt_q    <= bar_cnt_d;
            sub_tick_q   <= sub_tick_d;
            beat_tick_q  <= beat_tick_d;
            count_in_q   <= count_in_d;
            period_err_q <= period_err_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_vld_q   <= pend_vld_d;
        end
    end

    assign o_state      = state_q;
    assign o_sub_tick   = sub_tick_q;
    assign o_beat_tick  = beat_tick_q;
    assign o_sub_idx    = sub_idx_q;
    assign o_beat_idx   = beat_idx_q;
    assign o_bar_cnt    = bar_cnt_q;
    assign o_count_in   = count_in_q;
    assign o_period_err = period_err_q;

endmodule
`default_nettype wire

// File: tb/tb_beat_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_beat_scheduler
//  Description : Directed self-checking bench for beat_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_beat_scheduler;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic        pause   = 1'b0;
    logic        stop    = 1'b0;
    logic        wr      = 1'b0;
    logic [19:0] period  = '0;

    logic [1:0]  o_state;
    logic        o_sub_tick;
    logic        o_beat_tick;
    logic [1:0]  o_sub_idx;
    logic [1:0]  o_beat_idx;
    logic [7:0]  o_bar_cnt;
    logic        o_count_in;
    logic        o_period_err;

    int checks = 0;
    int errors = 0;

    beat_scheduler dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_pause      (pause),
        .i_stop       (stop),
        .i_period_wr  (wr),
        .i_period     (period),
        .o_state      (o_state),
        .o_sub_tick   (o_sub_tick),
        .o_beat_tick  (o_beat_tick),
        .o_sub_idx    (o_sub_idx),
        .o_beat_idx   (o_beat_idx),
        .o_bar_cnt    (o_bar_cnt),
        .o_count_in   (o_count_in),
        .o_period_err (o_period_err)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        checks++;
        if ({o_state, o_sub_tick, o_beat_tick, o_sub_idx, o_count_in, o_period_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %h expected %h",
                     {o_state, o_sub_tick, o_beat_tick, o_sub_idx, o_count_in, o_period_err}, 8'h00);
        end
        checks++;
        if (o_beat_idx !== 2'd3) begin
            errors++;
            $display("FAIL reset_beat_idx: got %0d expected 3", o_beat_idx);
        end
        checks++;
        if (o_bar_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_bar_cnt: got %0d expected 0", o_bar_cnt);
        end
        rst_n = 1'b1;
        step(1);
    endtask

    // P=4 loaded in IDLE, then one bar of count-in and one bar of RUN.
    task automatic test_count_in();
        logic [16:0] got;
        logic [16:0] exp;
        wr = 1'b1; period = 20'd4;
        step(1);
        wr = 1'b0;
        checks++;
        if (o_period_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_write_err: got %b expected 0", o_period_err);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        checks++;
        if ({o_state, o_count_in, o_sub_tick} !== 4'b0110) begin
            errors++;
            $display("FAIL start_state: got %b expected 0110", {o_state, o_count_in, o_sub_tick});
        end
        for (int k = 1; k <= 128; k++) begin
            step(1);
            got = {o_state, o_sub_tick, o_beat_tick, o_sub_idx, o_beat_idx, o_bar_cnt, o_count_in};
            exp = {(k < 64) ? 2'd1 : 2'd2,
                   (k % 4) == 0,
                   (k % 16) == 0,
                   2'((k / 4) % 4),
                   2'(3 - ((k / 16) % 4)),
                   (k >= 128) ? 8'd1 : 8'd0,
                   k < 64};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL count_in_cycle_%0d: got %h expected %h", k, got, exp);
            end
        end
    endtask

    // Enters just after a sub tick (sub_idx 0, beat 3, bar 1, RUN, P=4).
    task automatic test_pause();
        step(4);
        step(1);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        checks++;
        if ({o_state, o_sub_tick, o_sub_idx} !== 5'b11001) begin
            errors++;
            $display("FAIL pause_entry: got %b expected 11001", {o_state, o_sub_tick, o_sub_idx});
        end
        for (int k = 0; k < 50; k++) begin
            step(1);
            checks++;
            if ({o_state, o_sub_tick, o_beat_tick, o_sub_idx} !== 6'b110001) begin
                errors++;
                $display("FAIL pause_hold_%0d: got %b expected 110001", k,
                         {o_state, o_sub_tick, o_beat_tick, o_sub_idx});
            end
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        checks++;
        if ({o_state, o_sub_tick} !== 3'b100) begin
            errors++;
            $display("FAIL resume_edge: got %b expected 100", {o_state, o_sub_tick});
        end
        step(1);
        checks++;
        if (o_sub_tick !== 1'b0) begin
            errors++;
            $display("FAIL resume_plus1: got %b expected 0", o_sub_tick);
        end
        step(1);
        checks++;
        if ({o_sub_tick, o_sub_idx} !== 3'b110) begin
            errors++;
            $display("FAIL resume_plus2: got %b expected 110", {o_sub_tick, o_sub_idx});
        end
    endtask

    // Enters on a tick with sub_idx 2, beat 3.
    task automatic test_period_err();
        step(1);
        wr = 1'b1; period = 20'd1;
        step(1);
        wr = 1'b0;
        checks++;
        if ({o_period_err, o_sub_tick} !== 2'b10) begin
            errors++;
            $display("FAIL err_pulse: got %b expected 10", {o_period_err, o_sub_tick});
        end
        step(1);
        checks++;
        if (o_period_err !== 1'b0) begin
            errors++;
            $display("FAIL err_single: got %b expected 0", o_period_err);
        end
        for (int j = 4; j <= 8; j++) begin
            step(1);
            checks++;
            if ({o_sub_tick, o_beat_tick} !== {(j == 4) || (j == 8), j == 8}) begin
                errors++;
                $display("FAIL err_spacing_%0d: got %b expected %b", j,
                         {o_sub_tick, o_beat_tick}, {(j == 4) || (j == 8), j == 8});
            end
        end
        checks++;
        if ({o_sub_idx, o_beat_idx} !== 4'b0010) begin
            errors++;
            $display("FAIL err_indices: got %b expected 0010", {o_sub_idx, o_beat_idx});
        end
    endtask

    // Enters on a beat tick (sub 0, beat 2, P=4); change to P=8 mid-beat.
    task automatic test_period_change();
        logic [1:0] exp;
        step(1);
        wr = 1'b1; period = 20'd8;
        step(1);
        wr = 1'b0;
        for (int j = 3; j <= 48; j++) begin
            step(1);
            exp = {(j <= 16) ? ((j % 4) == 0) : ((j % 8) == 0), (j == 16) || (j == 48)};
            checks++;
            if ({o_sub_tick, o_beat_tick} !== exp) begin
                errors++;
                $display("FAIL tempo_change_%0d: got %b expected %b", j, {o_sub_tick, o_beat_tick}, exp);
            end
        end
        checks++;
        if (o_beat_idx !== 2'd0) begin
            errors++;
            $display("FAIL tempo_beat_idx: got %0d expected 0", o_beat_idx);
        end
        // A write sampled on a beat-tick edge waits one more beat.
        step(31);
        wr = 1'b1; period = 20'd4;
        step(1);
        wr = 1'b0;
        checks++;
        if ({o_beat_tick, o_bar_cnt} !== {1'b1, 8'd2}) begin
            errors++;
            $display("FAIL beat_edge_write: got %h expected %h", {o_beat_tick, o_bar_cnt}, {1'b1, 8'd2});
        end
        step(4);
        checks++;
        if (o_sub_tick !== 1'b0) begin
            errors++;
            $display("FAIL beat_edge_still8_a: got %b expected 0", o_sub_tick);
        end
        step(4);
        checks++;
        if (o_sub_tick !== 1'b1) begin
            errors++;
            $display("FAIL beat_edge_still8_b: got %b expected 1", o_sub_tick);
        end
        step(24);
        checks++;
        if (o_beat_tick !== 1'b1) begin
            errors++;
            $display("FAIL beat_edge_load: got %b expected 1", o_beat_tick);
        end
        step(4);
        checks++;
        if ({o_sub_tick, o_sub_idx} !== 3'b101) begin
            errors++;
            $display("FAIL beat_edge_now4: got %b expected 101", {o_sub_tick, o_sub_idx});
        end
    endtask

    // Stop and start together on an edge that would have carried a tick.
    task automatic test_stop_start();
        step(3);
        stop = 1'b1; start = 1'b1;
        step(1);
        stop = 1'b0; start = 1'b0;
        checks++;
        if ({o_state, o_sub_tick, o_beat_tick, o_sub_idx, o_beat_idx, o_count_in} !== 9'b000000110) begin
            errors++;
            $display("FAIL stop_start: got %b expected 000000110",
                     {o_state, o_sub_tick, o_beat_tick, o_sub_idx, o_beat_idx, o_count_in});
        end
        checks++;
        if (o_bar_cnt !== 8'd0) begin
            errors++;
            $display("FAIL stop_bar_cnt: got %0d expected 0", o_bar_cnt);
        end
        step(1);
        checks++;
        if (o_state !== 2'd0) begin
            errors++;
            $display("FAIL stop_stays_idle: got %0d expected 0", o_state);
        end
    endtask

    // P=2: one bar is 32 cycles; 256 bars wrap the bar counter.
    task automatic test_bar_wrap();
        wr = 1'b1; period = 20'd2;
        step(1);
        wr = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(32);
        checks++;
        if ({o_state, o_bar_cnt} !== {2'd2, 8'd0}) begin
            errors++;
            $display("FAIL wrap_run_entry: got %h expected %h", {o_state, o_bar_cnt}, {2'd2, 8'd0});
        end
        step(8160);
        checks++;
        if ({o_state, o_bar_cnt, o_beat_tick} !== {2'd2, 8'd255, 1'b1}) begin
            errors++;
            $display("FAIL wrap_255: got %h expected %h", {o_state, o_bar_cnt, o_beat_tick}, {2'd2, 8'd255, 1'b1});
        end
        step(31);
        checks++;
        if (o_bar_cnt !== 8'd255) begin
            errors++;
            $display("FAIL wrap_hold_255: got %0d expected 255", o_bar_cnt);
        end
        step(1);
        checks++;
        if ({o_state, o_bar_cnt, o_beat_tick} !== {2'd2, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL wrap_to_0: got %h expected %h", {o_state, o_bar_cnt, o_beat_tick}, {2'd2, 8'd0, 1'b1});
        end
    endtask

    // Reset asserted between clock edges takes effect without a clock.
    task automatic test_async_reset();
        step(3);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_state, o_sub_tick, o_beat_tick, o_sub_idx, o_beat_idx, o_bar_cnt} !== {2'd0, 1'b0, 1'b0, 2'd0, 2'd3, 8'd0}) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h",
                     {o_state, o_sub_tick, o_beat_tick, o_sub_idx, o_beat_idx, o_bar_cnt},
                     {2'd0, 1'b0, 1'b0, 2'd0, 2'd3, 8'd0});
        end
        step(1);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_count_in();
        test_pause();
        test_period_err();
        test_period_change();
        test_stop_start();
        test_bar_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
